core_control_sequencer: RTL and testbench



---
 rtl/core_control_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_core_control_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/core_control_sequencer.sv
// Multi-cycle control FSM for the JZJCoreF datapath: fetch, decode, memory, writeback.
// Classifies the decoded opcode/funct3, drives datapath strobes, keeps retire/cycle counters.
module core_control_sequencer #(
  parameter int unsigned MAX_WAIT      = 255,
  parameter int unsigned COUNTER_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic                     branch_taken,
  input  logic                     mem_ready,
  output logic                     fetch_request,
  output logic                     instruction_load,
  output logic                     mem_request,
  output logic                     mem_write,
  output logic                     pc_write,
  output logic [1:0]               pc_source,
  output logic                     rd_write,
  output logic [2:0]               state,
  output logic                     illegal,
  output logic                     timeout,
  output logic [COUNTER_WIDTH-1:0] instret,
  output logic [COUNTER_WIDTH-1:0] cycle_count
);

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_MEMORY    = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [7:0]               WAIT_LIMIT = 8'(MAX_WAIT);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE    = COUNTER_WIDTH'(1);

  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
    logic ok;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_IMM, OP_OP, OP_MISC, OP_SYSTEM: ok = 1'b1;
      OP_JALR:   ok = (f3 == 3'b000);
      OP_BRANCH: ok = (f3 != 3'b010) && (f3 != 3'b011);
      OP_LOAD:   ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                      (f3 == 3'b100) || (f3 == 3'b101);
      OP_STORE:  ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t                   state_q, state_d;
  logic [7:0]               wait_q, wait_d;
  logic                     illegal_q, illegal_d;
  logic                     timeout_q, timeout_d;
  logic [COUNTER_WIDTH-1:0] instret_q, instret_d;
  logic [COUNTER_WIDTH-1:0] cycle_q, cycle_d;
  logic [7:0]               wait_inc_s;
  logic                     is_mem_op_s;

  assign wait_inc_s  = wait_q + 8'd1;
  assign is_mem_op_s = (opcode == OP_LOAD) || (opcode == OP_STORE);

  // Next-state, sticky flags and counters.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    instret_d = instret_q;
    if (state_q != ST_HALT) begin
      cycle_d = cycle_q + CNT_ONE;
    end else begin
      cycle_d = cycle_q;
    end
    case (state_q)
      ST_FETCH, ST_MEMORY: begin
        if (mem_ready) begin
          state_d = (state_q == ST_FETCH) ? ST_DECODE : ST_WRITEBACK;
          wait_d  = 8'd0;
        end else if (wait_inc_s == WAIT_LIMIT) begin
          // Ready on the limit cycle wins, so the limit is checked only when not ready.
          state_d   = ST_HALT;
          timeout_d = 1'b1;
          wait_d    = wait_inc_s;
        end else begin
          wait_d = wait_inc_s;
        end
      end
      ST_DECODE: begin
        if (!is_legal(opcode, funct3)) begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end else if (opcode == OP_SYSTEM) begin
          state_d = ST_HALT;
        end else if (is_mem_op_s) begin
          state_d = ST_MEMORY;
          wait_d  = 8'd0;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: begin
        state_d   = ST_FETCH;
        wait_d    = 8'd0;
        instret_d = instret_q + CNT_ONE;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      wait_q    <= 8'd0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      instret_q <= '0;
      cycle_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      instret_q <= instret_d;
      cycle_q   <= cycle_d;
    end
  end

  // Datapath strobes decoded from the registered state; forced low while reset is held.
  always_comb begin
    fetch_request    = 1'b0;
    instruction_load = 1'b0;
    mem_request      = 1'b0;
    mem_write        = 1'b0;
    pc_write         = 1'b0;
    pc_source        = 2'd0;
    rd_write         = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          fetch_request    = 1'b1;
          instruction_load = mem_ready;
        end
        ST_MEMORY: begin
          mem_request = 1'b1;
          mem_write   = (opcode == OP_STORE);
        end
        ST_WRITEBACK: begin
          pc_write = 1'b1;
          rd_write = (opcode != OP_BRANCH) && (opcode != OP_STORE) && (opcode != OP_MISC);
          if ((opcode == OP_JAL) || (opcode == OP_JALR)) begin
            pc_source = 2'd2;
          end else if ((opcode == OP_BRANCH) && branch_taken) begin
            pc_source = 2'd1;
          end else begin
            pc_source = 2'd0;
          end
        end
        default: begin
          fetch_request = 1'b0;
        end
      endcase
    end else begin
      fetch_request = 1'b0;
    end
  end

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign instret     = instret_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_core_control_sequencer.sv
// Directed bench for core_control_sequencer with hand-computed expectations (MAX_WAIT=4).
module tb_core_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        branch_taken;
  logic        mem_ready;
  logic        fetch_request, instruction_load, mem_request, mem_write, pc_write, rd_write;
  logic [1:0]  pc_source;
  logic [2:0]  state;
  logic        illegal, timeout;
  logic [63:0] instret, cycle_count;

  int total = 0;
  int bad   = 0;

  core_control_sequencer #(.MAX_WAIT(4), .COUNTER_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .fetch_request(fetch_request), .instruction_load(instruction_load),
    .mem_request(mem_request), .mem_write(mem_write), .pc_write(pc_write),
    .pc_source(pc_source), .rd_write(rd_write), .state(state),
    .illegal(illegal), .timeout(timeout), .instret(instret), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3);
    opcode = op;
    funct3 = f3;
  endtask

  function automatic logic [6:0] strobes();
    return {fetch_request, instruction_load, mem_request, mem_write, pc_write, rd_write, |pc_source};
  endfunction

  initial begin
    rst_n = 1'b0; opcode = 7'd0; funct3 = 3'd0; branch_taken = 1'b0; mem_ready = 1'b1;
    #12;
    check_eq("rst_state", state, 64'd0);
    check_eq("rst_strobes", strobes(), 64'd0);
    check_eq("rst_flags", {illegal, timeout}, 64'd0);
    check_eq("rst_cnt", instret | cycle_count, 64'd0);

    // ADDI x1,x0,5 (0x00500093)
    set_instr(7'b0010011, 3'b000);
    rst_n = 1'b1;
    #1;
    check_eq("addi_fetch", {state, fetch_request, instruction_load}, {3'd0, 1'b1, 1'b1});
    tick(); check_eq("addi_decode", state, 64'd1);
    tick();
    check_eq("addi_wb", {state, pc_write, rd_write, pc_source}, {3'd3, 1'b1, 1'b1, 2'd0});
    check_eq("addi_instret_pre", instret, 64'd0);
    tick();
    check_eq("addi_state_end", state, 64'd0);
    check_eq("addi_instret", instret, 64'd1);
    check_eq("addi_cycles", cycle_count, 64'd3);

    // SW x2,0(x1) (0x0020A023), two memory stall cycles
    set_instr(7'b0100011, 3'b010);
    tick(); check_eq("sw_decode", state, 64'd1);
    mem_ready = 1'b0;
    tick(); check_eq("sw_mem1", {state, mem_request, mem_write}, {3'd2, 1'b1, 1'b1});
    tick(); check_eq("sw_mem2", {state, mem_request, mem_write}, {3'd2, 1'b1, 1'b1});
    tick(); mem_ready = 1'b1; #1;
    check_eq("sw_mem3", {state, mem_request, mem_write}, {3'd2, 1'b1, 1'b1});
    tick(); check_eq("sw_wb", {state, pc_write, rd_write, mem_request}, {3'd3, 1'b1, 1'b0, 1'b0});
    tick();
    check_eq("sw_instret", instret, 64'd2);
    check_eq("sw_cycles", cycle_count, 64'd9);

    // BEQ taken, then not taken
    set_instr(7'b1100011, 3'b000);
    branch_taken = 1'b1;
    tick(); tick();
    check_eq("beq_t_wb", {state, pc_source, rd_write, pc_write}, {3'd3, 2'd1, 1'b0, 1'b1});
    tick(); branch_taken = 1'b0;
    tick(); tick();
    check_eq("beq_n_wb", {state, pc_source, rd_write, pc_write}, {3'd3, 2'd0, 1'b0, 1'b1});
    tick();

    // JAL
    set_instr(7'b1101111, 3'b000);
    tick(); tick();
    check_eq("jal_wb", {state, pc_source, rd_write}, {3'd3, 2'd2, 1'b1});
    tick();
    check_eq("jal_instret", instret, 64'd5);
    check_eq("jal_cycles", cycle_count, 64'd18);

    // Fetch timeout: mem_ready stuck low
    mem_ready = 1'b0;
    #1;
    check_eq("to_load_low", instruction_load, 64'd0);
    tick(); tick(); tick();
    check_eq("to_before", {state, timeout}, {3'd0, 1'b0});
    tick();
    check_eq("to_fired", {state, timeout, illegal}, {3'd4, 1'b1, 1'b0});
    mem_ready = 1'b1;
    tick(); tick(); tick();
    check_eq("to_frozen", {state, strobes()}, {3'd4, 7'd0});
    check_eq("to_cycles", cycle_count, 64'd22);
    check_eq("to_instret", instret, 64'd5);

    // Ready arriving on the limit cycle wins
    pulse_reset();
    set_instr(7'b0010011, 3'b000);
    mem_ready = 1'b0;
    tick(); tick(); tick();
    mem_ready = 1'b1; #1;
    check_eq("rdy_limit_load", {state, instruction_load, timeout}, {3'd0, 1'b1, 1'b0});
    tick();
    check_eq("rdy_limit_dec", {state, timeout}, {3'd1, 1'b0});

    // Illegal opcode 0x7F
    pulse_reset();
    set_instr(7'b1111111, 3'b000);
    tick(); tick();
    check_eq("ill_halt", {state, illegal, timeout}, {3'd4, 1'b1, 1'b0});
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("ill_frozen", {state, illegal, strobes()}, {3'd4, 1'b1, 7'd0});
    end
    check_eq("ill_cnt", {instret[31:0], cycle_count[31:0]}, {32'd0, 32'd2});

    // JALR with funct3=001 is illegal
    pulse_reset();
    set_instr(7'b1100111, 3'b001);
    tick(); tick();
    check_eq("jalr_ill", {state, illegal}, {3'd4, 1'b1});

    // SYSTEM halts without flagging illegal
    pulse_reset();
    set_instr(7'b1110011, 3'b000);
    tick(); tick();
    check_eq("sys_halt", {state, illegal, timeout}, {3'd4, 1'b0, 1'b0});

    // Reset pulsed during MEMORY of a load
    pulse_reset();
    set_instr(7'b0000011, 3'b010);
    tick(); tick();
    mem_ready = 1'b0; #1;
    check_eq("lw_mem", {state, mem_request, mem_write}, {3'd2, 1'b1, 1'b0});
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_state", state, 64'd0);
    check_eq("mid_rst_strobes", strobes(), 64'd0);
    check_eq("mid_rst_cnt", instret | cycle_count, 64'd0);
    rst_n = 1'b1;
    mem_ready = 1'b1; #1;
    check_eq("mid_rst_fetch", {state, fetch_request, instruction_load}, {3'd0, 1'b1, 1'b1});
    tick();
    check_eq("mid_rst_decode", {state, cycle_count[7:0]}, {3'd1, 8'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
